pwm_multimode_core: RTL and testbench

PWM_MULTIMODE_CORE -- requirements
Module: pwm_multimode_core

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/pwm_timebase.sv | 83 ++++++++
 rtl/pwm_multimode_core.sv | 128 ++++++++++++
 tb/tb_pwm_multimode_core.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Register map, CTRL/STATUS bit positions and mode encoding shared by the PWM core.
package pwm_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DVSR   = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'h01;
  localparam logic [ADDR_W-1:0] ADDR_CH_EN  = 5'h02;
  localparam logic [ADDR_W-1:0] ADDR_INV    = 5'h03;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'h04;
  localparam logic [ADDR_W-1:0] ADDR_DUTY   = 5'h10;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_MODE_BIT   = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;
  localparam int unsigned STATUS_PD_BIT   = 0;
  localparam int unsigned STATUS_CNT_LSB  = 16;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_e;

  typedef struct packed {
    logic      irq_en;
    pwm_mode_e mode;
    logic      en;
  } ctrl_t;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus edge (up) / center (up-down) period counter with a boundary pulse.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned R = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  pwm_mode_e         mode,
  input  logic [DATA_W-1:0] dvsr,
  output logic [R-1:0]      d,
  output logic              tick,
  output logic              boundary
);

  localparam logic [R-1:0] D_MAX = '1;
  localparam logic [R-1:0] D_ONE = R'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  dir_e              dir_q;
  dir_e              dir_next;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] q_next;
  logic [R-1:0]      d_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q     <= '0;
      d     <= '0;
      dir_q <= DIR_UP;
    end else begin
      q     <= q_next;
      d     <= d_next;
      dir_q <= dir_next;
    end
  end

  assign tick = en && (q == '0);

  // Disabled timebase parks at the start of a fresh up-counting period.
  always_comb begin
    q_next   = '0;
    d_next   = '0;
    dir_next = DIR_UP;
    boundary = 1'b0;
    if (en) begin
      q_next   = (q >= dvsr) ? '0 : q + DATA_W'(1);
      d_next   = d;
      dir_next = dir_q;
      if (tick) begin
        if (mode == EDGE) begin
          d_next   = d + D_ONE;
          dir_next = DIR_UP;
          boundary = (d == D_MAX);
        end else begin
          case (dir_q)
            DIR_UP: begin
              if (d == D_MAX) begin
                d_next   = d - D_ONE;
                dir_next = DIR_DOWN;
              end else begin
                d_next = d + D_ONE;
              end
            end
            default: begin
              d_next = d - D_ONE;
              if (d == D_ONE) begin
                dir_next = DIR_UP;
                boundary = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/pwm_multimode_core.sv
// Multi-channel PWM with register slot, shadowed duties and period-done interrupt.
module pwm_multimode_core
  import pwm_pkg::*;
#(
  parameter int unsigned R = 10,
  parameter int unsigned W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [W-1:0]      pwm_out,
  output logic              irq
);

  localparam int unsigned DUTY_W = R + 1;

  logic [DATA_W-1:0] dvsr;
  ctrl_t             ctrl;
  logic [W-1:0]      ch_en;
  logic [W-1:0]      inv;
  logic [DUTY_W-1:0] shadow [W];
  logic [DUTY_W-1:0] active [W];
  pwm_mode_e         active_mode;
  logic              period_done;
  logic              period_done_next_c;
  logic              wr_en_c;
  logic [R-1:0]      d;
  logic              tick;
  logic              boundary;
  logic              unused_c;

  assign wr_en_c  = cs && write;
  assign unused_c = ^{read, tick};

  pwm_timebase #(
    .R (R)
  ) u_timebase (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl.en),
    .mode     (active_mode),
    .dvsr     (dvsr),
    .d        (d),
    .tick     (tick),
    .boundary (boundary)
  );

  // A boundary wins over a simultaneous write-1-to-clear.
  always_comb begin
    period_done_next_c = period_done;
    if (boundary) begin
      period_done_next_c = 1'b1;
    end else if (wr_en_c && (addr == ADDR_STATUS) && wr_data[STATUS_PD_BIT]) begin
      period_done_next_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvsr        <= '0;
      ctrl        <= '0;
      ch_en       <= '0;
      inv         <= '0;
      active_mode <= EDGE;
      period_done <= 1'b0;
      irq         <= 1'b0;
      pwm_out     <= '0;
      for (int i = 0; i < W; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en_c) begin
        case (addr)
          ADDR_DVSR:  dvsr <= wr_data;
          ADDR_CTRL: begin
            ctrl.en     <= wr_data[CTRL_EN_BIT];
            ctrl.mode   <= pwm_mode_e'(wr_data[CTRL_MODE_BIT]);
            ctrl.irq_en <= wr_data[CTRL_IRQ_EN_BIT];
          end
          ADDR_CH_EN: ch_en <= wr_data[W-1:0];
          ADDR_INV:   inv   <= wr_data[W-1:0];
          default: ;
        endcase
        for (int i = 0; i < W; i++) begin
          if (addr == ADDR_DUTY + ADDR_W'(i)) shadow[i] <= wr_data[DUTY_W-1:0];
        end
      end

      // Shadow duties and mode go live only at a period boundary or while stopped.
      if (!ctrl.en || boundary) begin
        active_mode <= ctrl.mode;
        for (int i = 0; i < W; i++) active[i] <= shadow[i];
      end

      for (int i = 0; i < W; i++) begin
        pwm_out[i] <= (ctrl.en && ch_en[i] && ({1'b0, d} < active[i])) ^ inv[i];
      end
      period_done <= period_done_next_c;
      irq         <= period_done_next_c && ctrl.irq_en;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_DVSR:  rd_data = dvsr;
      ADDR_CTRL:  rd_data = DATA_W'(ctrl);
      ADDR_CH_EN: rd_data = DATA_W'(ch_en);
      ADDR_INV:   rd_data = DATA_W'(inv);
      ADDR_STATUS: begin
        rd_data[STATUS_PD_BIT]          = period_done;
        rd_data[STATUS_CNT_LSB +: R]    = d;
      end
      default: begin
        for (int i = 0; i < W; i++) begin
          if (addr == ADDR_DUTY + ADDR_W'(i)) rd_data = DATA_W'(shadow[i]);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_multimode_core.sv
// Randomized and directed checks of pwm_multimode_core (R=4, W=2) against a period-position model.
module tb_pwm_multimode_core;

  localparam int unsigned R    = 4;
  localparam int unsigned W    = 2;
  localparam int          NCNT = 16;

  localparam logic [4:0] A_DVSR   = 5'h00;
  localparam logic [4:0] A_CTRL   = 5'h01;
  localparam logic [4:0] A_CH_EN  = 5'h02;
  localparam logic [4:0] A_INV    = 5'h03;
  localparam logic [4:0] A_STATUS = 5'h04;
  localparam logic [4:0] A_DUTY0  = 5'h10;
  localparam logic [4:0] A_DUTY1  = 5'h11;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [W-1:0] pwm_out;
  logic        irq;

  int n_tests;
  int n_fail;
  string phase;

  // Reference model: period position p, d derived from p and the active mode.
  int unsigned m_dvsr;
  int unsigned m_q;
  int          m_p;
  bit          m_en, m_mode, m_irqen, m_amode, m_pd;
  bit [1:0]    m_chen, m_inv;
  int          m_shadow [W];
  int          m_active [W];
  bit [1:0]    exp_pwm;
  bit          exp_irq;

  pwm_multimode_core #(
    .R (R),
    .W (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int m_period();
    return m_amode ? 2 * NCNT - 2 : NCNT;
  endfunction

  function automatic int m_d();
    return (!m_amode || m_p < NCNT) ? m_p : 2 * NCNT - 2 - m_p;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      A_DVSR:   return m_dvsr;
      A_CTRL:   return {29'b0, m_irqen, m_mode, m_en};
      A_CH_EN:  return {30'b0, m_chen};
      A_INV:    return {30'b0, m_inv};
      A_STATUS: return (32'(m_d()) << 16) | 32'(m_pd);
      A_DUTY0:  return 32'(m_shadow[0]);
      A_DUTY1:  return 32'(m_shadow[1]);
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_dvsr = 0; m_q = 0; m_p = 0;
    m_en = 0; m_mode = 0; m_irqen = 0; m_amode = 0; m_pd = 0;
    m_chen = 0; m_inv = 0; exp_pwm = 0; exp_irq = 0;
    for (int i = 0; i < W; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
  endtask

  task automatic model_edge(input bit we, input logic [4:0] a, input logic [31:0] data);
    int          d;
    bit          tk;
    bit          bnd;
    int          np;
    int unsigned nq;
    d   = m_d();
    tk  = m_en && (m_q == 0);
    bnd = 0;
    np  = 0;
    nq  = 0;
    if (m_en) begin
      nq = (m_q >= m_dvsr) ? 0 : m_q + 1;
      np = m_p;
      if (tk) begin
        np  = (m_p + 1) % m_period();
        bnd = (np == 0);
      end
    end
    for (int i = 0; i < W; i++)
      exp_pwm[i] = (m_en && m_chen[i] && (d < m_active[i])) ^ m_inv[i];
    if (!m_en || bnd) begin
      m_amode = m_mode;
      for (int i = 0; i < W; i++) m_active[i] = m_shadow[i];
    end
    if (bnd) m_pd = 1;
    else if (we && a == A_STATUS && data[0]) m_pd = 0;
    exp_irq = m_pd && m_irqen;
    m_q = nq;
    m_p = np;
    if (we) begin
      case (a)
        A_DVSR:  m_dvsr = data;
        A_CTRL:  begin m_en = data[0]; m_mode = data[1]; m_irqen = data[2]; end
        A_CH_EN: m_chen = data[1:0];
        A_INV:   m_inv = data[1:0];
        A_DUTY0: m_shadow[0] = int'(data[4:0]);
        A_DUTY1: m_shadow[1] = int'(data[4:0]);
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input bit c, input bit w, input logic [4:0] a, input logic [31:0] data);
    @(negedge clk);
    cs = c; write = w; read = c & ~w; addr = a; wr_data = data;
    #1;
    check_eq({phase, ".rd_data"}, rd_data, m_read(a));
    @(posedge clk);
    model_edge(c && w, a, data);
    #1;
    check_eq({phase, ".pwm_out"}, 32'(pwm_out), 32'(exp_pwm));
    check_eq({phase, ".irq"}, 32'(irq), 32'(exp_irq));
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] data);
    cycle(1'b1, 1'b1, a, data);
  endtask

  task automatic idle(input int n, input logic [4:0] ra);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, ra, 32'd0);
  endtask

  task automatic count_high(input int n, input logic [4:0] ra, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, 1'b0, ra, 32'd0);
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
    end
  endtask

  task automatic wait_d(input int target);
    bit found;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_d() == target) found = 1;
      else cycle(1'b0, 1'b0, A_STATUS, 32'd0);
    end
    if (!found) check_eq({phase, ".wait_d_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_pre_boundary();
    bit found;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_en && m_q == 0 && ((m_p + 1) % m_period()) == 0) found = 1;
      else cycle(1'b0, 1'b0, A_STATUS, 32'd0);
    end
    if (!found) check_eq({phase, ".wait_bnd_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int c0, c1;
    int r;
    bit c, w;
    n_tests = 0;
    n_fail  = 0;
    phase   = "reset";
    reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; addr = A_DVSR; wr_data = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset.pwm_out", 32'(pwm_out), 32'd0);
    check_eq("reset.irq", 32'(irq), 32'd0);
    check_eq("reset.dvsr", rd_data, 32'd0);
    reset = 1'b1;

    phase = "edge_basic";
    wr(A_DVSR, 32'd0);
    wr(A_CH_EN, 32'd3);
    wr(A_DUTY0, 32'd5);
    wr(A_DUTY1, 32'd16);
    wr(A_CTRL, 32'd1);
    idle(4, A_STATUS);
    count_high(32, A_STATUS, c0, c1);
    check_eq("edge_basic.ch0_high", 32'(c0), 32'd10);
    check_eq("edge_basic.ch1_high", 32'(c1), 32'd32);

    phase = "shadow";
    wait_d(7);
    wr(A_DUTY0, 32'd12);
    idle(20, A_DUTY0);
    count_high(32, A_STATUS, c0, c1);
    check_eq("shadow.ch0_high", 32'(c0), 32'd24);

    phase = "center";
    wr(A_CTRL, 32'd0);
    wr(A_CTRL, 32'd2);
    wr(A_DUTY0, 32'd4);
    wr(A_CTRL, 32'd3);
    idle(6, A_STATUS);
    count_high(60, A_STATUS, c0, c1);
    check_eq("center.ch0_high", 32'(c0), 32'd14);
    check_eq("center.ch1_high", 32'(c1), 32'd60);

    phase = "invert";
    wr(A_CTRL, 32'd0);
    wr(A_DVSR, 32'd2);
    wr(A_INV, 32'd1);
    wr(A_DUTY0, 32'd0);
    wr(A_CTRL, 32'd1);
    idle(3, A_STATUS);
    count_high(30, A_STATUS, c0, c1);
    check_eq("invert.ch0_high", 32'(c0), 32'd30);
    wr(A_INV, 32'd0);
    wr(A_DVSR, 32'd0);

    phase = "irq";
    wr(A_CTRL, 32'd5);
    wait_d(3);
    wr(A_STATUS, 32'd1);
    check_eq("irq.w1c_clear", 32'(irq), 32'd0);
    wait_pre_boundary();
    check_eq("irq.before_boundary", 32'(irq), 32'd0);
    idle(1, A_STATUS);
    check_eq("irq.after_boundary", 32'(irq), 32'd1);
    wait_d(5);
    wr(A_STATUS, 32'd1);
    wait_pre_boundary();
    wr(A_STATUS, 32'd1);
    check_eq("irq.w1c_on_boundary", 32'(irq), 32'd1);
    wr(A_STATUS, 32'd1);
    check_eq("irq.w1c_after", 32'(irq), 32'd0);

    phase = "midreset";
    wait_d(9);
    @(negedge clk);
    cs = 1'b0; write = 1'b0; read = 1'b0; addr = A_STATUS;
    #2 reset = 1'b0;
    #1;
    check_eq("midreset.async_pwm", 32'(pwm_out), 32'd0);
    check_eq("midreset.async_irq", 32'(irq), 32'd0);
    check_eq("midreset.status", rd_data, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    wr(A_CTRL, 32'd1);
    cs = 1'b0; write = 1'b0; addr = A_STATUS;
    #1;
    check_eq("midreset.d_first", 32'(rd_data[19:16]), 32'd0);
    idle(1, A_STATUS);
    #1;
    check_eq("midreset.d_second", 32'(rd_data[19:16]), 32'd1);

    phase = "random";
    wr(A_CH_EN, 32'd3);
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 11);
      c = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 9) != 0);
      case (r)
        0: cycle(c, w, A_DVSR, 32'($urandom_range(0, 3)));
        1: cycle(c, w, A_CTRL, $urandom);
        2: cycle(c, w, A_CH_EN, $urandom);
        3: cycle(c, w, A_INV, $urandom);
        4: cycle(c, w, 5'(A_DUTY0 + 5'($urandom_range(0, 3))), $urandom);
        5: cycle(c, w, A_STATUS, $urandom);
        6: cycle(c, w, 5'($urandom_range(5, 15)), $urandom);
        7: cycle(c, w, 5'($urandom_range(18, 31)), $urandom);
        default: cycle(c, 1'b0, 5'($urandom_range(0, 31)), $urandom);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
